// File: rtl/t07_spi_tft_writer.sv
// Write-only SPI (mode 0, MSB first) bridge from the MMIO display window to a TFT panel.
// Stalls the CPU through busyTFT_o for the whole transfer plus the CS hold time.
`timescale 1ns/1ps

module t07_spi_tft_writer #(
    parameter int CLK_DIV   = 2,
    parameter int BASE_ADDR = 1792
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        displayWrite_i,
    input  logic [31:0] displayAddr_i,
    input  logic [31:0] displayData_i,
    output logic        busyTFT_o,
    output logic        spi_sclk_o,
    output logic        spi_mosi_o,
    output logic        spi_cs_n_o,
    output logic        spi_dc_o
);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        HOLD,
        DONE
    } state_t;

    localparam int                DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    state_t            state_q, state_d;
    logic [31:0]       shift_q;
    logic [5:0]        bit_cnt_q;
    logic [DIV_W-1:0]  div_q;
    logic              sclk_q, cs_n_q, dc_q;

    logic [31:0]       off;
    logic              mapped;
    logic [31:0]       load_word;
    logic [5:0]        load_cnt;
    logic              load_dc;
    logic              accept, half_end, last_fall;

    // Payload is left-aligned so the first bit out is always shift_q[31].
    // NOTE: every signal assigned in always_comb gets a default first, otherwise a latch is inferred.
    always_comb begin
        off       = displayAddr_i - 32'(BASE_ADDR);
        mapped    = 1'b1;
        load_word = '0;
        load_cnt  = '0;
        load_dc   = 1'b1;
        case (off)
            32'd1: begin
                load_word = {displayData_i[7:0], 24'h0};
                load_cnt  = 6'd8;
                load_dc   = 1'b0;
            end
            32'd2: begin
                load_word = {displayData_i[7:0], 24'h0};
                load_cnt  = 6'd8;
            end
            32'd3: begin
                load_word = {displayData_i[15:0], 16'h0};
                load_cnt  = 6'd16;
            end
            32'd4: begin
                load_word = displayData_i;
                load_cnt  = 6'd32;
            end
            default: mapped = 1'b0;
        endcase
    end

    assign accept    = (state_q == IDLE) && displayWrite_i && mapped;
    assign half_end  = (div_q == DIV_LAST);
    assign last_fall = sclk_q && half_end && (bit_cnt_q == 6'd1);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)    state_d = SHIFT;
            SHIFT:   if (last_fall) state_d = HOLD;
            HOLD:    if (half_end)  state_d = DONE;
            DONE:                   state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    // Shift path: SCLK rises at the end of a low half, falls (and shifts) at the end of a high half.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            shift_q   <= '0;
            bit_cnt_q <= '0;
            div_q     <= '0;
            sclk_q    <= 1'b0;
            cs_n_q    <= 1'b1;
            dc_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        shift_q   <= load_word;
                        bit_cnt_q <= load_cnt;
                        dc_q      <= load_dc;
                        cs_n_q    <= 1'b0;
                        div_q     <= '0;
                        sclk_q    <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (half_end) begin
                        div_q <= '0;
                        if (!sclk_q) begin
                            sclk_q <= 1'b1;
                        end else begin
                            sclk_q    <= 1'b0;
                            shift_q   <= {shift_q[30:0], 1'b0};
                            bit_cnt_q <= bit_cnt_q - 6'd1;
                        end
                    end else begin
                        div_q <= div_q + DIV_W'(1);
                    end
                end
                HOLD: begin
                    if (half_end) begin
                        div_q  <= '0;
                        cs_n_q <= 1'b1;
                    end else begin
                        div_q <= div_q + DIV_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // After the last bit has been shifted out the register is all zeros, so MOSI idles low.
    always_comb begin
        busyTFT_o  = nrst && (accept || (state_q == SHIFT) || (state_q == HOLD));
        spi_sclk_o = sclk_q;
        spi_mosi_o = shift_q[31];
        spi_cs_n_o = cs_n_q;
        spi_dc_o   = dc_q;
    end

endmodule
